// File: rtl/port_fifo_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : port_fifo_pkg
// Purpose  : Shared sizing constants, bus address map and helpers for the
//            ingress port FIFO bank.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package port_fifo_pkg;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int NPORTS = 3;
  localparam int PTR_W  = $clog2(DEPTH);

  // Word addresses decoded on address[2:0]
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_PORT0  = 3'd1;
  localparam logic [2:0] ADDR_PORT1  = 3'd2;
  localparam logic [2:0] ADDR_PORT2  = 3'd3;

  // Port p lives at ADDR_PORT0 + p; ports are contiguous in the map.
  function automatic logic [2:0] port_addr(input int p);
    return ADDR_PORT0 + 3'(p);
  endfunction

endpackage
`default_nettype wire

// File: rtl/port_fifo_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : port_fifo_bank_if
// Purpose  : Host bus plus scheduler-side signals of the port FIFO bank.
// Ports    : master - host/scheduler side (drives bus strobes and rdreq)
//            slave  - port_fifo_bank side (drives readdata, q and flags)
// Revision : 1.0 - initial release
// ============================================================================
interface port_fifo_bank_if;
  import port_fifo_pkg::*;

  // Host bus
  logic                         chipselect;
  logic                         write;
  logic                         read;
  logic [3:0]                   address;
  logic [31:0]                  writedata;
  logic [3:0]                   byteenable;
  logic [31:0]                  readdata;

  // Scheduler side
  logic [NPORTS-1:0]            rdreq;
  logic [NPORTS-1:0][WIDTH-1:0] q;
  logic [NPORTS-1:0]            empty;
  logic [NPORTS-1:0]            full;
  logic [NPORTS-1:0][PTR_W-1:0] usedw;

  modport master (
    output chipselect, write, read, address, writedata, byteenable, rdreq,
    input  readdata, q, empty, full, usedw
  );

  modport slave (
    input  chipselect, write, read, address, writedata, byteenable, rdreq,
    output readdata, q, empty, full, usedw
  );

endinterface
`default_nettype wire

// File: rtl/port_fifo_bank_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock circular-buffer FIFO with a registered read port.
// Ports    : clk, reset_n      - clock, async active-low reset
//            wrreq, din        - enqueue request and data
//            rdreq, dout       - dequeue request and registered head word
//            empty, full       - occupancy flags
//            usedw             - count modulo DEPTH (reads 0 when full)
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       reset_n,
  input  wire logic                       wrreq,
  input  wire logic [WIDTH-1:0]           din,
  input  wire logic                       rdreq,
  output logic      [WIDTH-1:0]           dout,
  output logic                            empty,
  output logic                            full,
  output logic      [$clog2(DEPTH)-1:0]   usedw
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic [WIDTH-1:0] r_dout;

  logic w_wr_ok;
  logic w_rd_ok;

  assign empty = (r_count == '0);
  assign full  = (r_count == C_FULL_COUNT);
  assign usedw = r_count[PTR_W-1:0];
  assign dout  = r_dout;

  // Both requests are judged against the pre-edge flags, so a write into a
  // full FIFO is refused even when a read frees a slot on the same edge.
  assign w_wr_ok = wrreq && !full;
  assign w_rd_ok = rdreq && !empty;

  // Storage carries no reset; only words behind the valid pointers are read.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + PTR_W'(1);
        r_dout <= r_mem[r_rptr];
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/port_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : port_fifo_bank
// Purpose  : Ingress queue stage. Host bus writes are decoded to one of three
//            per-port FIFOs; each port's head word is re-registered for the
//            scheduler, and a status word is readable at address 0.
// Ports    : clk, reset_n - clock, async active-low reset
//            bus (slave)  - host bus strobes/data/readdata, per-port rdreq,
//                           q, empty, full, usedw
// Revision : 1.0 - initial release
// ============================================================================
module port_fifo_bank #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int NPORTS = 3
) (
  input wire logic        clk,
  input wire logic        reset_n,
  port_fifo_bank_if.slave bus
);
  import port_fifo_pkg::*;

  localparam int USEDW_W = $clog2(DEPTH);

  logic [NPORTS-1:0]              w_wr_sel;
  logic                           w_status_rd;
  logic [31:0]                    w_status;
  logic [NPORTS-1:0]              r_wrreq;
  logic [NPORTS-1:0][WIDTH-1:0]   r_din;
  logic [NPORTS-1:0][WIDTH-1:0]   w_fifo_dout;
  logic [NPORTS-1:0][WIDTH-1:0]   r_q;
  logic [NPORTS-1:0]              w_empty;
  logic [NPORTS-1:0]              w_full;
  logic [NPORTS-1:0][USEDW_W-1:0] w_usedw;
  logic [31:0]                    r_readdata;

  // Full-word writes only; address bit 3 is outside the decoded map.
  logic w_unused;
  assign w_unused = ^{bus.byteenable, bus.address[3]};

  always_comb begin
    w_wr_sel = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_wr_sel[p] = bus.chipselect && bus.write &&
                    (bus.address[2:0] == port_addr(p));
    end
  end

  assign w_status_rd = bus.chipselect && bus.read &&
                       (bus.address[2:0] == ADDR_STATUS);

  // Per port p: usedw in [3p+1:3p], full at 3p+2, empty at 16+p.
  always_comb begin
    w_status = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_status[3*p +: 2] = w_usedw[p][1:0];
      w_status[3*p + 2]  = w_full[p];
      w_status[16 + p]   = w_empty[p];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrreq    <= '0;
      r_din      <= '0;
      r_q        <= '0;
      r_readdata <= '0;
    end else begin
      // wrreq is a one-cycle pulse per decoded write, so a burst to one
      // port enqueues exactly one word per cycle.
      r_wrreq <= w_wr_sel;
      for (int p = 0; p < NPORTS; p++) begin
        if (w_wr_sel[p]) begin
          r_din[p] <= bus.writedata;
        end
      end
      r_q <= w_fifo_dout;
      if (w_status_rd) begin
        r_readdata <= w_status;
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wrreq   (r_wrreq[p]),
      .din     (r_din[p]),
      .rdreq   (bus.rdreq[p]),
      .dout    (w_fifo_dout[p]),
      .empty   (w_empty[p]),
      .full    (w_full[p]),
      .usedw   (w_usedw[p])
    );
  end

  assign bus.q        = r_q;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.usedw    = w_usedw;
  assign bus.readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_port_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_fifo_bank
// Purpose  : Directed self-checking bench for port_fifo_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_port_fifo_bank;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  port_fifo_bank_if bus ();

  port_fifo_bank dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic status_read();
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 4'd0;
    tick();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  // Dequeue one word and wait until it reaches q.
  task automatic read_port(input int p);
    bus.rdreq[p] = 1'b1;
    tick();
    bus.rdreq[p] = 1'b0;
    tick();
  endtask

  task automatic check_reset_state(input string pfx);
    check_value({pfx, "_q0"},    bus.q[0], 32'h0);
    check_value({pfx, "_q1"},    bus.q[1], 32'h0);
    check_value({pfx, "_q2"},    bus.q[2], 32'h0);
    check_value({pfx, "_empty"}, 32'(bus.empty), 32'h7);
    check_value({pfx, "_full"},  32'(bus.full),  32'h0);
    check_value({pfx, "_usedw"}, 32'(bus.usedw), 32'h0);
    check_value({pfx, "_rdata"}, bus.readdata, 32'h0);
  endtask

  initial begin
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = 4'd0;
    bus.writedata  = 32'h0;
    bus.byteenable = 4'hF;
    bus.rdreq      = '0;

    // Power-on reset
    #1 reset_n = 1'b0;
    tick();
    tick();
    check_reset_state("por");
    reset_n = 1'b1;
    tick();

    // Single enqueue / dequeue on port 0
    bus_write(4'd1, 32'hDEADBEEF);
    tick();
    check_value("single_empty0", 32'(bus.empty[0]), 32'h0);
    check_value("single_usedw0", 32'(bus.usedw[0]), 32'h1);
    bus.rdreq[0] = 1'b1;
    tick();
    bus.rdreq[0] = 1'b0;
    check_value("single_q0_lat", bus.q[0], 32'h0);
    check_value("single_usedw0_dec", 32'(bus.usedw[0]), 32'h0);
    check_value("single_empty0_set", 32'(bus.empty[0]), 32'h1);
    tick();
    check_value("single_q0", bus.q[0], 32'hDEADBEEF);

    // Fill port 1 back-to-back, fifth word overflows
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 4'd2;
    for (int i = 1; i <= 5; i++) begin
      bus.writedata = 32'(i);
      tick();
    end
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    tick();
    check_value("fill_full1",  32'(bus.full[1]),  32'h1);
    check_value("fill_usedw1", 32'(bus.usedw[1]), 32'h0);
    check_value("fill_empty1", 32'(bus.empty[1]), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      read_port(1);
      check_value($sformatf("fill_q1_%0d", i), bus.q[1], 32'(i));
    end
    check_value("fill_drained1", 32'(bus.empty[1]), 32'h1);
    read_port(1);
    check_value("underflow_q1_hold", bus.q[1], 32'h4);
    check_value("underflow_usedw1", 32'(bus.usedw[1]), 32'h0);

    // Routing isolation
    bus_write(4'd3, 32'hA);
    bus_write(4'd0, 32'hB);
    bus_write(4'd5, 32'hB);
    tick();
    check_value("route_empty", 32'(bus.empty), 32'h3);
    check_value("route_usedw2", 32'(bus.usedw[2]), 32'h1);
    check_value("route_full", 32'(bus.full), 32'h0);
    read_port(2);
    check_value("route_q2", bus.q[2], 32'hA);
    check_value("route_all_empty", 32'(bus.empty), 32'h7);

    // Simultaneous write and read at count 2
    bus_write(4'd1, 32'h10);
    bus_write(4'd1, 32'h11);
    tick();
    check_value("sim_pre_usedw0", 32'(bus.usedw[0]), 32'h2);
    bus_write(4'd1, 32'h12);
    bus.rdreq[0] = 1'b1;
    tick();
    bus.rdreq[0] = 1'b0;
    check_value("sim_usedw0", 32'(bus.usedw[0]), 32'h2);
    tick();
    check_value("sim_q0_a", bus.q[0], 32'h10);
    read_port(0);
    check_value("sim_q0_b", bus.q[0], 32'h11);
    read_port(0);
    check_value("sim_q0_c", bus.q[0], 32'h12);
    check_value("sim_empty0", 32'(bus.empty[0]), 32'h1);

    // Simultaneous write and read while full: write refused
    for (int i = 0; i < 4; i++) bus_write(4'd1, 32'h20 + 32'(i));
    tick();
    check_value("simfull_full0", 32'(bus.full[0]), 32'h1);
    bus_write(4'd1, 32'h24);
    bus.rdreq[0] = 1'b1;
    tick();
    bus.rdreq[0] = 1'b0;
    check_value("simfull_usedw0", 32'(bus.usedw[0]), 32'h3);
    check_value("simfull_notfull0", 32'(bus.full[0]), 32'h0);
    tick();
    check_value("simfull_q0_0", bus.q[0], 32'h20);
    for (int i = 1; i < 4; i++) begin
      read_port(0);
      check_value($sformatf("simfull_q0_%0d", i), bus.q[0], 32'h20 + 32'(i));
    end
    check_value("simfull_dropped", 32'(bus.empty[0]), 32'h1);

    // Status word
    bus_write(4'd1, 32'h30);
    bus_write(4'd1, 32'h31);
    for (int i = 0; i < 4; i++) bus_write(4'd2, 32'h40 + 32'(i));
    tick();
    status_read();
    check_value("status_a", bus.readdata, 32'h0004_0022);
    bus_write(4'd3, 32'h50);
    tick();
    check_value("status_hold", bus.readdata, 32'h0004_0022);
    status_read();
    check_value("status_b", bus.readdata, 32'h0000_0062);

    // Asynchronous reset in the middle of traffic
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 4'd1;
    bus.writedata  = 32'h77;
    bus.rdreq      = 3'b010;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_reset_state("midrst");
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.rdreq      = '0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check_value("postrst_empty", 32'(bus.empty), 32'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
